// File: rtl/axis2fifo_pkg.sv
// Shared types and lane-geometry helpers for the AXIS-to-FIFO pixel packer.
package axis2fifo_pkg;

    typedef enum logic {SYNC, ACTIVE} state_t;

    function automatic int lane_bytes(input int pixel_width);
        return (pixel_width <= 8) ? 1 : (pixel_width <= 16) ? 2 : 4;
    endfunction

    function automatic int pix_per_word(input int data_width, input int pixel_width);
        return data_width / 8 / lane_bytes(pixel_width);
    endfunction

endpackage

// File: rtl/axis2fifo_word_asm.sv
// Packs pixels into FIFO words: lane accumulator, lane index, pending word and its sof tag.
module axis2fifo_word_asm
    import axis2fifo_pkg::*;
#(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_DATA_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     push_sof,
    input  logic                     discard,
    input  logic                     pop,
    input  logic [C_PIXEL_WIDTH-1:0] pix,
    output logic [C_DATA_WIDTH-1:0]  word,
    output logic                     pending,
    output logic                     sof
);
    localparam int LANE_W    = 8 * lane_bytes(C_PIXEL_WIDTH);
    localparam int NUM_LANES = pix_per_word(C_DATA_WIDTH, C_PIXEL_WIDTH);
    localparam int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [NUM_LANES-1:0][LANE_W-1:0] lanes, lanes_nxt;
    logic [IDX_W-1:0]                 idx, idx_eff;
    logic                             sof_acc, sof_eff, last_lane;

    // discard restarts the word so a pixel pushed in the same cycle lands in lane 0
    always_comb begin
        idx_eff            = discard ? '0 : idx;
        lanes_nxt          = lanes;
        lanes_nxt[idx_eff] = LANE_W'(pix);
        sof_eff            = (idx_eff == '0) ? push_sof : sof_acc;
        last_lane          = (idx_eff == IDX_W'(NUM_LANES - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes   <= '0;
            idx     <= '0;
            sof_acc <= 1'b0;
            word    <= '0;
            pending <= 1'b0;
            sof     <= 1'b0;
        end else if (flush) begin
            idx     <= '0;
            sof_acc <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (pop)
                pending <= 1'b0;
            if (push) begin
                lanes   <= lanes_nxt;
                sof_acc <= sof_eff;
                if (last_lane) begin
                    word    <= C_DATA_WIDTH'(lanes_nxt);
                    sof     <= sof_eff;
                    pending <= 1'b1;
                    idx     <= '0;
                end else begin
                    idx <= idx_eff + IDX_W'(1);
                end
            end else if (discard) begin
                idx <= '0;
            end
        end
    end

endmodule

// File: rtl/axis2fifo_packer.sv
// S2MM front-end: AXIS pixel stream -> packed FIFO words with frame geometry checking.
// Optional AXIS2FIFO_ERR_CNT_EN builds a saturating geometry-error counter.
module axis2fifo_packer
    import axis2fifo_pkg::*;
#(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_IMG_WBITS   = 12,
    parameter int C_IMG_HBITS   = 12
) (
    input  logic                     S_AXIS_ACLK,
    input  logic                     S_AXIS_ARESET,
    input  logic                     soft_resetn,
    input  logic [C_IMG_WBITS-1:0]   img_width,
    input  logic [C_IMG_HBITS-1:0]   img_height,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     wr_en,
    output logic [C_DATA_WIDTH-1:0]  dout,
    output logic                     dout_sof,
    input  logic                     full,
    output logic                     frame_done,
    output logic                     geom_err,
    output logic [15:0]              err_count
);
    state_t                 state, state_nxt;
    logic [C_IMG_WBITS-1:0] col, col_nxt, cur_col, w_q, w_nxt, eff_w;
    logic [C_IMG_HBITS-1:0] row, row_nxt, cur_row, h_q, h_nxt, eff_h;
    logic hs, start, last_col, last_row;
    logic push, discard, err_now, done_set, done_pend, pending;

    assign s_axis_tready = ~S_AXIS_ARESET & soft_resetn & ((state == SYNC) | ~(pending & full));
    assign hs            = s_axis_tvalid & s_axis_tready;
    assign wr_en         = pending & ~full;
    assign frame_done    = wr_en & done_pend;

    // a tuser pixel is always evaluated as column 0 / row 0 of a fresh geometry
    always_comb begin
        start    = hs & s_axis_tuser;
        cur_col  = start ? '0 : col;
        cur_row  = start ? '0 : row;
        eff_w    = start ? img_width  : w_q;
        eff_h    = start ? img_height : h_q;
        last_col = (cur_col == eff_w - C_IMG_WBITS'(1));
        last_row = (cur_row == eff_h - C_IMG_HBITS'(1));

        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        w_nxt     = w_q;
        h_nxt     = h_q;
        push      = 1'b0;
        discard   = 1'b0;
        err_now   = 1'b0;
        done_set  = 1'b0;

        if (!soft_resetn) begin
            state_nxt = SYNC;
            col_nxt   = '0;
            row_nxt   = '0;
        end else if (hs && (state == ACTIVE || start)) begin
            if (start) begin
                w_nxt     = img_width;
                h_nxt     = img_height;
                discard   = 1'b1;
                err_now   = (state == ACTIVE);
                state_nxt = ACTIVE;
            end
            if (s_axis_tlast != last_col) begin
                err_now   = 1'b1;
                discard   = 1'b1;
                state_nxt = SYNC;
                col_nxt   = '0;
                row_nxt   = '0;
            end else begin
                push = 1'b1;
                if (last_col) begin
                    col_nxt = '0;
                    if (last_row) begin
                        state_nxt = SYNC;
                        row_nxt   = '0;
                        done_set  = 1'b1;
                    end else begin
                        row_nxt = cur_row + C_IMG_HBITS'(1);
                    end
                end else begin
                    col_nxt = cur_col + C_IMG_WBITS'(1);
                end
            end
        end
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state     <= SYNC;
            col       <= '0;
            row       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            geom_err  <= 1'b0;
            done_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            col      <= col_nxt;
            row      <= row_nxt;
            w_q      <= w_nxt;
            h_q      <= h_nxt;
            geom_err <= err_now;
            // the frame's last word always completes on the done_set push
            if (!soft_resetn)
                done_pend <= 1'b0;
            else if (done_set)
                done_pend <= 1'b1;
            else if (wr_en)
                done_pend <= 1'b0;
        end
    end

    axis2fifo_word_asm #(
        .C_PIXEL_WIDTH(C_PIXEL_WIDTH),
        .C_DATA_WIDTH (C_DATA_WIDTH)
    ) u_word_asm (
        .clk     (S_AXIS_ACLK),
        .rst     (S_AXIS_ARESET),
        .flush   (~soft_resetn),
        .push    (push),
        .push_sof(start),
        .discard (discard),
        .pop     (wr_en),
        .pix     (s_axis_tdata),
        .word    (dout),
        .pending (pending),
        .sof     (dout_sof)
    );

`ifdef AXIS2FIFO_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET)
            err_cnt_q <= '0;
        else if (geom_err && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 16'd1;
    end
    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_axis2fifo_packer.sv
// Directed bench for axis2fifo_packer: 8-bit pixels, 32-bit words, 8x2 frames.
module tb_axis2fifo_packer;
    logic        S_AXIS_ACLK = 1'b0;
    logic        S_AXIS_ARESET = 1'b1;
    logic        soft_resetn = 1'b1;
    logic [11:0] img_width = 12'd8;
    logic [11:0] img_height = 12'd2;
    logic        s_axis_tvalid = 1'b0;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic        wr_en;
    logic [31:0] dout;
    logic        dout_sof;
    logic        full = 1'b0;
    logic        frame_done;
    logic        geom_err;
    logic [15:0] err_count;

    axis2fifo_packer dut (
        .S_AXIS_ACLK  (S_AXIS_ACLK),
        .S_AXIS_ARESET(S_AXIS_ARESET),
        .soft_resetn  (soft_resetn),
        .img_width    (img_width),
        .img_height   (img_height),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .wr_en        (wr_en),
        .dout         (dout),
        .dout_sof     (dout_sof),
        .full         (full),
        .frame_done   (frame_done),
        .geom_err     (geom_err),
        .err_count    (err_count)
    );

    always #5 S_AXIS_ACLK = ~S_AXIS_ACLK;

    int          n_tests = 0;
    int          n_fail = 0;
    int          n_err = 0;
    logic [31:0] got_w[$], exp_w[$];
    logic        got_s[$], exp_s[$], got_d[$], exp_d[$];

    always @(negedge S_AXIS_ACLK) begin
        #2;
        if (wr_en) begin
            got_w.push_back(dout);
            got_s.push_back(dout_sof);
            got_d.push_back(frame_done);
        end
        if (geom_err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic px(input logic [7:0] d, input logic u, input logic l);
        int n = 0;
        @(negedge S_AXIS_ACLK);
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l;
        #1;
        while (!s_axis_tready && n < 100) begin
            @(negedge S_AXIS_ACLK); #1; n++;
        end
        if (n >= 100) check("tready_timeout", {31'd0, s_axis_tready}, 32'd1);
        @(posedge S_AXIS_ACLK);
    endtask

    task automatic idle(input int cycles);
        @(negedge S_AXIS_ACLK);
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        repeat (cycles) @(negedge S_AXIS_ACLK);
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 8; c++)
                px(base + 8'(r * 8 + c), (r == 0 && c == 0), (c == 7));
    endtask

    task automatic expect_word(input logic [31:0] w, input logic s, input logic d);
        exp_w.push_back(w); exp_s.push_back(s); exp_d.push_back(d);
    endtask

    task automatic expect_frame(input logic [7:0] base);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = base + 8'(4 * k);
            expect_word({b + 8'd3, b + 8'd2, b + 8'd1, b}, (k == 0), (k == 3));
        end
    endtask

    task automatic compare(input string tag, input int errs);
        int n;
        idle(10);
        check({tag, "_nwords"}, got_w.size(), exp_w.size());
        n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d", tag, i), got_w[i], exp_w[i]);
            check($sformatf("%s_sof%0d", tag, i), {31'd0, got_s[i]}, {31'd0, exp_s[i]});
            check($sformatf("%s_done%0d", tag, i), {31'd0, got_d[i]}, {31'd0, exp_d[i]});
        end
        check({tag, "_geom_err"}, n_err, errs);
        got_w.delete(); got_s.delete(); got_d.delete();
        exp_w.delete(); exp_s.delete(); exp_d.delete();
        n_err = 0;
    endtask

    logic stall_seen;

    initial begin
        #12;
        check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_sof", {31'd0, dout_sof}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_geom", {31'd0, geom_err}, 32'd0);
        check("rst_errcnt", {16'd0, err_count}, 32'd0);
        @(negedge S_AXIS_ACLK); S_AXIS_ARESET = 1'b0;
        idle(2);

        // clean frame
        send_frame(8'h01);
        expect_frame(8'h01);
        compare("t1", 0);

        // full backpressure after first word
        stall_seen = 1'b0;
        fork
            send_frame(8'h01);
            begin
                int n = 0;
                while (!wr_en && n < 200) begin @(negedge S_AXIS_ACLK); #3; n++; end
                @(posedge S_AXIS_ACLK); #1 full = 1'b1;
                repeat (5) begin
                    @(negedge S_AXIS_ACLK); #3;
                    if (!s_axis_tready) stall_seen = 1'b1;
                end
                @(posedge S_AXIS_ACLK); #1 full = 1'b0;
            end
        join
        check("t2_stall", {31'd0, stall_seen}, 32'd1);
        expect_frame(8'h01);
        compare("t2", 0);

        // early tlast on pixel 5, junk, then good frame
        px(8'h01, 1, 0); px(8'h02, 0, 0); px(8'h03, 0, 0); px(8'h04, 0, 0);
        px(8'h05, 0, 1); px(8'h06, 0, 0); px(8'h07, 0, 1);
        send_frame(8'h21);
        expect_word(32'h04030201, 1, 0);
        expect_frame(8'h21);
        compare("t3", 1);

        // tuser on pixel 6 restarts the frame
        for (int i = 1; i <= 5; i++) px(8'(i), (i == 1), 0);
        send_frame(8'h31);
        expect_word(32'h04030201, 1, 0);
        expect_frame(8'h31);
        compare("t4", 1);

        // soft reset mid-line
        for (int i = 1; i <= 6; i++) px(8'(i), (i == 1), 0);
        @(negedge S_AXIS_ACLK);
        soft_resetn = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = 8'h77; s_axis_tuser = 1'b0;
        repeat (3) begin
            @(negedge S_AXIS_ACLK); #3;
            check("t5_wr_en", {31'd0, wr_en}, 32'd0);
            check("t5_tready", {31'd0, s_axis_tready}, 32'd0);
        end
        soft_resetn = 1'b1;
        px(8'h55, 0, 0);
        send_frame(8'h41);
        expect_word(32'h04030201, 1, 0);
        expect_frame(8'h41);
        compare("t5", 0);

        // hard reset with a pending word about to write
        full = 1'b1;
        for (int i = 1; i <= 4; i++) px(8'(i), (i == 1), 0);
        @(negedge S_AXIS_ACLK);
        s_axis_tvalid = 1'b0; full = 1'b0; S_AXIS_ARESET = 1'b1;
        #1;
        check("t6_wr_en", {31'd0, wr_en}, 32'd0);
        check("t6_tready", {31'd0, s_axis_tready}, 32'd0);
        check("t6_dout", dout, 32'd0);
        check("t6_sof", {31'd0, dout_sof}, 32'd0);
        check("t6_done", {31'd0, frame_done}, 32'd0);
        check("t6_geom", {31'd0, geom_err}, 32'd0);
        check("t6_errcnt", {16'd0, err_count}, 32'd0);
        repeat (2) @(negedge S_AXIS_ACLK);
        S_AXIS_ARESET = 1'b0;
        send_frame(8'h51);
        expect_frame(8'h51);
        compare("t6", 0);

        // three early-tlast errors
        repeat (3) begin
            px(8'h01, 1, 0); px(8'h02, 0, 1);
        end
        compare("t7", 3);
`ifdef AXIS2FIFO_ERR_CNT_EN
        check("t7_errcnt", {16'd0, err_count}, 32'd3);
`else
        check("t7_errcnt", {16'd0, err_count}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
